lsu_stage: RTL

LSU_STAGE -- requirements
Module: lsu_stage

---
 rtl/npc_lsu_pkg.sv | 58 +++++
 rtl/lsu_align.sv | 68 ++++++
 rtl/lsu_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/npc_lsu_pkg.sv
// -----------------------------------------------------------------------------
// npc_lsu_pkg
//   Shared definitions for the load/store stage:
//     - XLEN                  : data/address bus width
//     - MEMOP_*               : RISC-V funct3 encodings of load/store width
//     - lsu_state_t           : FSM state encoding of lsu_stage
//     - lsu_size_t            : decoded access width
//     - memop_size()          : funct3 -> access width (undefined codes -> word)
//     - memop_misaligned()    : natural-alignment test used by the trap option
// -----------------------------------------------------------------------------
package npc_lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Codes 011, 110 and 111 have no meaning for loads/stores here; they fall
  // through to a full-word access.
  function automatic lsu_size_t memop_size(input logic [2:0] memop);
    lsu_size_t sz;
    case (memop)
      MEMOP_B, MEMOP_BU: sz = SZ_B;
      MEMOP_H, MEMOP_HU: sz = SZ_H;
      default:           sz = SZ_W;
    endcase
    return sz;
  endfunction

  // Halfwords must sit on an even address, words on a multiple of four.
  function automatic logic memop_misaligned(input logic [2:0] memop,
                                            input logic [1:0] lane);
    logic mis;
    case (memop_size(memop))
      SZ_H:    mis = lane[0];
      SZ_W:    mis = (lane != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Purely combinational byte-lane logic for the load/store stage.
//   Ports:
//     lane       in  [1:0]  byte offset of the access (addr[1:0])
//     memop      in  [2:0]  funct3 width/sign code
//     wr         in         1 = store, 0 = load
//     wdata      in  [31:0] store data as it came from rs2
//     rdata      in  [31:0] raw word returned by the bus
//     wmask      out [3:0]  byte enables (0000 for loads)
//     wdata_lane out [31:0] store data moved into its byte lane (0 for loads)
//     rdata_ext  out [31:0] load field shifted down and sign/zero extended
//   Masks are computed in 4 bits, so an H access at lane 3 simply loses its
//   upper byte rather than spilling into a second bus word.
// -----------------------------------------------------------------------------
module lsu_align
  import npc_lsu_pkg::*;
(
  input  logic [1:0]      lane,
  input  logic [2:0]      memop,
  input  logic            wr,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      wmask,
  output logic [XLEN-1:0] wdata_lane,
  output logic [XLEN-1:0] rdata_ext
);

  logic [4:0]  shamt;
  logic [15:0] field;
  lsu_size_t   size;

  assign shamt = {lane, 3'b000};
  assign size  = memop_size(memop);
  // Only the low 16 bits of the shifted-down word are ever a B/H field.
  assign field = 16'(rdata >> shamt);

  always_comb begin
    wmask      = 4'b0000;
    wdata_lane = '0;
    rdata_ext  = '0;
    case (size)
      SZ_B: begin
        wmask      = 4'b0001 << lane;
        wdata_lane = {24'b0, wdata[7:0]} << shamt;
        // memop[2] distinguishes BU/HU (zero-extend) from B/H (sign-extend).
        rdata_ext  = memop[2] ? {24'b0, field[7:0]}
                              : {{24{field[7]}}, field[7:0]};
      end
      SZ_H: begin
        wmask      = 4'b0011 << lane;
        wdata_lane = {16'b0, wdata[15:0]} << shamt;
        rdata_ext  = memop[2] ? {16'b0, field}
                              : {{16{field[15]}}, field};
      end
      default: begin
        wmask      = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
      end
    endcase
    if (!wr) begin
      wmask      = 4'b0000;
      wdata_lane = '0;
    end
  end

endmodule

// File: rtl/lsu_stage.sv
// -----------------------------------------------------------------------------
// lsu_stage
//   Single-outstanding load/store stage between execute and writeback.
//   One op is accepted in IDLE, issued on the bus in REQ, its response awaited
//   in WAIT and the result presented in DONE until writeback takes it.
//
//   Handshakes: every valid/ready pair transfers on a rising clock edge where
//   both are high; a valid, once raised, keeps its payload stable until that
//   edge, and a ready seen while its valid is low has no effect.
//
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     in_valid/in_ready             op offer from execute (ready only in IDLE)
//     in_addr, in_wdata             effective address, store data
//     in_memop, in_wr               funct3 width code, 1 = store
//     mem_req_valid/mem_req_ready   bus request handshake
//     mem_addr                      word-aligned request address
//     mem_wen, mem_wmask, mem_wdata store enable, byte mask, lane data
//     mem_rsp_valid, mem_rdata      bus response (load data or store ack)
//     out_valid/out_ready           result handshake to writeback
//     out_rdata                     extended load data, 0 for stores
//     out_err                       misaligned-access fault (with out_valid)
//     dbg_state                     current FSM state
//
//   Build option LSU_MISALIGN_TRAP_EN: misaligned H/W ops are not sent to the
//   bus; they go straight to DONE with out_err = 1 and out_rdata = 0. Without
//   it out_err is 0 and misaligned ops use the normal lane rules.
// -----------------------------------------------------------------------------
module lsu_stage
  import npc_lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [2:0]      in_memop,
  input  logic            in_wr,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [3:0]      mem_wmask,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_err,
  output lsu_state_t      dbg_state
);

  lsu_state_t      state_q, state_d;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      memop_q;
  logic            wr_q;
  logic [XLEN-1:0] rdata_q;
  logic            accept;
  logic            in_req, in_done;

  logic [3:0]      al_wmask;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
  logic            err_q;
  logic            in_mis;
  assign in_mis = memop_misaligned(in_memop, in_addr[1:0]);
`endif

  // in_ready is also held low while rst is asserted so nothing can be
  // latched in the same cycle the stage is being cleared.
  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign in_req   = (state_q == ST_REQ);
  assign in_done  = (state_q == ST_DONE);

  // The aligner works on the latched op so the bus payload is stable for the
  // whole REQ phase regardless of what execute drives meanwhile.
  lsu_align u_align (
    .lane       (addr_q[1:0]),
    .memop      (memop_q),
    .wr         (wr_q),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .wmask      (al_wmask),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
          state_d = in_mis ? ST_DONE : ST_REQ;
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
      // The response is only looked at here, never in the REQ handshake cycle.
      ST_WAIT: if (mem_rsp_valid) state_d = ST_DONE;
      ST_DONE: if (out_ready)     state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and op registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      memop_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        memop_q <= in_memop;
        wr_q    <= in_wr;
        rdata_q <= '0;
      end else if ((state_q == ST_WAIT) && mem_rsp_valid) begin
        // A store's response is just an acknowledge; its result is 0.
        rdata_q <= wr_q ? '0 : al_rdata;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= in_mis;
    end
  end
  assign out_err = in_done && err_q;
`else
  assign out_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: bus and result payloads are forced to 0 outside their phase so
  // that a freshly reset stage shows all-zero outputs.
  // ---------------------------------------------------------------------------
  assign mem_req_valid = in_req;
  assign mem_addr      = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem_wen       = in_req && wr_q;
  assign mem_wmask     = in_req ? al_wmask : 4'b0000;
  assign mem_wdata     = in_req ? al_wdata : '0;
  assign out_valid     = in_done;
  assign out_rdata     = in_done ? rdata_q : '0;
  assign dbg_state     = state_q;

endmodule
